// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority / round-robin arbiter.
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {IDLE, GRANT} state_t;

    // One-hot vector for an index; indices outside 0..n-1 give all zeros.
    function automatic logic [31:0] onehot_of(input int unsigned idx, input int unsigned n);
        logic [31:0] vec;
        vec = '0;
        if (idx < n && idx < 32)
            vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface prio_arbiter_if #(parameter int N = 8) ();

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output req, done, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_valid);

endinterface

// File: rtl/prio_enc_n.sv
// Combinational highest-bit-wins encoder; in round-robin mode it first tries
// only the requests below the last winner, which avoids a rotator.
module prio_enc_n
    import prio_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = MODE_FIXED,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] masked;
    logic [N-1:0] search;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            if (RR_MODE == MODE_RR && (IDX_W + 1)'(i) < {1'b0, last_idx})
                masked[i] = req[i];
        end
        search = (|masked) ? masked : req;
    end

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (search[i])
                idx = IDX_W'(i);
        end
        any = |req;
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: picks a winner from IDLE, then holds the grant
// until the owner pulses done. One dead IDLE cycle separates grants.
module prio_arbiter
    import prio_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = MODE_FIXED,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    prio_arbiter_if.slave  bus
);

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    prio_enc_n #(
        .N       (N),
        .RR_MODE (RR_MODE)
    ) u_enc (
        .req      (bus.req),
        .last_idx (last_q),
        .idx      (enc_idx),
        .any      (enc_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // done is only looked at in GRANT, so a stray or held done in IDLE is harmless.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                idx_d = '0;
                if (enc_any) begin
                    state_d = GRANT;
                    idx_d   = enc_idx;
                    gnt_d   = N'(onehot_of(32'(enc_idx), N));
                    last_d  = enc_idx;
                end
            end
            GRANT: begin
                if (bus.done) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_prio_arbiter.sv
// Drives three arbiters (fixed N=8, round-robin N=8, round-robin N=5) and
// compares them every cycle against a search-order reference model.
module tb_prio_arbiter;
    import prio_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    prio_arbiter_if #(.N(8)) if0 ();
    prio_arbiter_if #(.N(8)) if1 ();
    prio_arbiter_if #(.N(5)) if2 ();

    prio_arbiter #(.N(8), .RR_MODE(MODE_FIXED)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    prio_arbiter #(.N(8), .RR_MODE(MODE_RR))    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    prio_arbiter #(.N(5), .RR_MODE(MODE_RR))    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [31:0] req_v [3];
    logic        done_v [3];
    logic [31:0] obs_gnt [3];
    logic [31:0] obs_idx [3];
    logic [31:0] obs_valid [3];

    assign if0.req  = req_v[0][7:0];
    assign if1.req  = req_v[1][7:0];
    assign if2.req  = req_v[2][4:0];
    assign if0.done = done_v[0];
    assign if1.done = done_v[1];
    assign if2.done = done_v[2];

    assign obs_gnt[0]   = 32'(if0.gnt);
    assign obs_gnt[1]   = 32'(if1.gnt);
    assign obs_gnt[2]   = 32'(if2.gnt);
    assign obs_idx[0]   = 32'(if0.gnt_idx);
    assign obs_idx[1]   = 32'(if1.gnt_idx);
    assign obs_idx[2]   = 32'(if2.gnt_idx);
    assign obs_valid[0] = 32'(if0.gnt_valid);
    assign obs_valid[1] = 32'(if1.gnt_valid);
    assign obs_valid[2] = 32'(if2.gnt_valid);

    int n_of [3]    = '{8, 8, 5};
    int mode_of [3] = '{MODE_FIXED, MODE_RR, MODE_RR};
    int m_valid [3];
    int m_idx [3];
    int m_last [3];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the requesters in the order the rules define and return the first hit.
    function automatic int pick(input int k, input logic [31:0] r);
        int n;
        int j;
        n = n_of[k];
        if (mode_of[k] == MODE_FIXED) begin
            for (int i = n - 1; i >= 0; i--)
                if (r[i]) return i;
        end else begin
            for (int s = 1; s <= n; s++) begin
                j = (m_last[k] - s + n) % n;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic modelEdge();
        int w;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_valid[k] = 0;
                m_idx[k]   = 0;
                m_last[k]  = 0;
            end else if (m_valid[k] == 0) begin
                w = pick(k, req_v[k]);
                if (w >= 0) begin
                    m_valid[k] = 1;
                    m_idx[k]   = w;
                    m_last[k]  = w;
                end
            end else if (done_v[k]) begin
                m_valid[k] = 0;
                m_idx[k]   = 0;
            end
        end
    endtask

    // One clock with the current inputs, then compare every arbiter with the model.
    task automatic applyStimulus();
        logic [31:0] exp_gnt;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_gnt = (m_valid[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0;
            checkOutput($sformatf("d%0d_gnt", k), obs_gnt[k], exp_gnt);
            checkOutput($sformatf("d%0d_idx", k), obs_idx[k], 32'(m_idx[k]));
            checkOutput($sformatf("d%0d_valid", k), obs_valid[k], 32'(m_valid[k]));
        end
    endtask

    task automatic setAll(input logic [31:0] r, input logic d);
        for (int k = 0; k < 3; k++) begin
            req_v[k]  = r;
            done_v[k] = d;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        setAll(32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            m_idx[k]   = 0;
            m_last[k]  = 0;
        end

        repeat (2) applyStimulus();
        checkOutput("rst_gnt", obs_gnt[0], 32'd0);
        checkOutput("rst_valid", obs_valid[1], 32'd0);
        rst_n = 1'b1;
        applyStimulus();

        // Fixed priority: highest set bit wins and is held without done.
        req_v[0] = 32'h24;
        applyStimulus();
        checkOutput("fix_gnt", obs_gnt[0], 32'h20);
        checkOutput("fix_idx", obs_idx[0], 32'd5);
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("fix_hold", obs_gnt[0], 32'h20);
        end
        done_v[0] = 1'b1;
        applyStimulus();
        checkOutput("fix_dead", obs_valid[0], 32'd0);
        done_v[0] = 1'b0;
        applyStimulus();
        checkOutput("fix_regrant", obs_idx[0], 32'd5);
        checkOutput("fix_regrant_v", obs_valid[0], 32'd1);
        req_v[0]  = 32'd0;
        done_v[0] = 1'b1;
        applyStimulus();
        done_v[0] = 1'b0;

        // Round-robin rotation, N=8 all requesting and N=5 wrap between 0 and 4.
        req_v[1] = 32'hFF;
        req_v[2] = 32'h11;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            checkOutput($sformatf("rr8_seq%0d", i), obs_idx[1], 32'((i == 8) ? 7 : 7 - i));
            checkOutput($sformatf("rr5_seq%0d", i), obs_idx[2], 32'((i % 2 == 0) ? 4 : 0));
            done_v[1] = 1'b1;
            done_v[2] = 1'b1;
            applyStimulus();
            checkOutput($sformatf("rr8_dead%0d", i), obs_valid[1], 32'd0);
            checkOutput($sformatf("rr5_dead%0d", i), obs_valid[2], 32'd0);
            done_v[1] = 1'b0;
            done_v[2] = 1'b0;
        end
        req_v[1] = 32'd0;
        req_v[2] = 32'd0;

        // Grant is never revoked by dropping req; done in IDLE does nothing.
        req_v[0] = 32'h08;
        applyStimulus();
        checkOutput("hold_gnt", obs_gnt[0], 32'h08);
        req_v[0] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("hold_noreq", obs_gnt[0], 32'h08);
        end
        done_v[0] = 1'b1;
        applyStimulus();
        checkOutput("hold_release", obs_gnt[0], 32'd0);
        applyStimulus();
        checkOutput("idle_done", obs_valid[0], 32'd0);
        done_v[0] = 1'b0;
        applyStimulus();
        checkOutput("idle_done_gnt", obs_gnt[0], 32'd0);

        // Reset during a held grant, then the round-robin pointer must be back at 0.
        req_v[0] = 32'h40;
        applyStimulus();
        checkOutput("pre_rst_idx", obs_idx[0], 32'd6);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("rst_drop_gnt", obs_gnt[0], 32'd0);
        checkOutput("rst_drop_valid", obs_valid[0], 32'd0);
        rst_n = 1'b1;
        req_v[0] = 32'hFF;
        req_v[1] = 32'hFF;
        req_v[2] = 32'h1F;
        applyStimulus();
        checkOutput("post_rst_fix", obs_idx[0], 32'd7);
        checkOutput("post_rst_rr8", obs_idx[1], 32'd7);
        checkOutput("post_rst_rr5", obs_idx[2], 32'd4);
        setAll(32'd0, 1'b1);
        applyStimulus();
        setAll(32'd0, 1'b0);

        // Random requests, releases and occasional resets.
        for (int c = 0; c < 10000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0)
                    req_v[k] = 32'd0;
                else
                    req_v[k] = $urandom & ((32'd1 << n_of[k]) - 32'd1);
                done_v[k] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
